uart_tx: RTL

- Serial UART transmitter; the transmit-side counterpart of the block's existing receiver.
- Pops bytes from an upstream first-word-fall-through FIFO.
- Serialises each byte as an 8N1-style frame: start bit low, data LSB first, stop bit(s) high. Each bit is held for a parameterised number of clocks.
- Sits between the host-side TX FIFO and the TX pad.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 39 +++
 rtl/uart_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default data width and line idle level.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned UART_DATAWIDTH  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_BIT_TX = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// tick_o is registered and always equals (count == terminal).
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned    CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Wrap after the terminal count; restart holds the count at zero.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_q) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == TERM);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= (TERM == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a FWFT FIFO and sends start/data/stop frames.
// Optional even/odd parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = UART_DATAWIDTH,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 ISEMPTY,
`ifdef UART_TX_PARITY_EN
  input  logic                 PARITY_ODD,
`endif
  input  logic [DATAWIDTH-1:0] DATA,
  output logic                 READ,
  output logic                 TX,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned    BW        = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATAWIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d, shift_nx;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d, read_q, read_d, busy_q, busy_d, done_q, done_d;
  logic                 tick, load, last_bit, last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d, par_bit;
  assign par_bit = par_q ^ PARITY_ODD;
`endif

  assign load      = EN && !ISEMPTY;
  assign last_bit  = (bit_cnt_q == LAST_BIT);
  assign last_stop = (bit_cnt_q == LAST_STOP);
  assign shift_nx  = shift_q >> 1;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .restart_i(state_q == ST_IDLE),
    .tick_o   (tick)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_START;
      ST_START:  if (tick) state_d = ST_BIT_TX;
      ST_BIT_TX: begin
        if (tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP:   if (tick && last_stop) state_d = load ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; TX leads the state by one edge.
  always_comb begin
    tx_d      = UART_IDLE_LEVEL;
    read_d    = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (load) begin
          shift_d = DATA;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          read_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^DATA;
`endif
        end
      end
      ST_START: tx_d = tick ? shift_q[0] : 1'b0;
      ST_BIT_TX: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = shift_nx;
          if (last_bit) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d      = par_bit;
`else
            tx_d      = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_nx[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = tick ? UART_IDLE_LEVEL : par_bit;
`endif
      ST_STOP: begin
        if (tick) begin
          if (last_stop) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            if (load) begin
              shift_d = DATA;
              tx_d    = 1'b0;
              read_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
              par_d   = ^DATA;
`endif
            end else begin
              busy_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        busy_d    = 1'b0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign TX   = tx_q;
  assign READ = read_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
